operand2_shifter: RTL and testbench

OPERAND2_SHIFTER -- requirements
Module: operand2_shifter

---
 rtl/op2_pkg.sv | 23 ++
 rtl/op2_rotator.sv | 30 +++
 rtl/operand2_shifter.sv | 201 ++++++++++++++++++++
 tb/tb_operand2_shifter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op2_pkg.sv
// Shared constants for the operand-2 shifter: shift types and the bit
// positions of the fields inside the 12-bit instruction shifter operand.
package op2_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_e;

  // Immediate shift amount and shift type.
  localparam int SO_SHAMT_MSB = 11;
  localparam int SO_SHAMT_LSB = 7;
  localparam int SO_TYPE_MSB  = 6;
  localparam int SO_TYPE_LSB  = 5;

  // Rotated-immediate encoding: 4-bit rotate field over an 8-bit constant.
  localparam int SO_ROT_MSB   = 11;
  localparam int SO_ROT_LSB   = 8;
  localparam int SO_IMM8_MSB  = 7;

endpackage

// File: rtl/op2_rotator.sv
// DATA_W-wide rotate-right used for every shift type. LSL is a rotate by
// DATA_W-n, whose last shifted-out bit lands in bit 0; every other type
// takes its carry from the result MSB.
module op2_rotator #(
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [AW-1:0]     amt_i,
  input  logic              lsl_i,
  output logic [DATA_W-1:0] rot_o,
  output logic              carry_o
);

  logic [DATA_W-1:0] stage;

  // Log-depth barrel: stage k rotates by 2**k when amt_i[k] is set.
  always_comb begin
    stage = data_i;
    for (int k = 0; k < AW; k++) begin
      if (amt_i[k]) begin
        stage = (stage >> (2**k)) | (stage << (DATA_W - 2**k));
      end
    end
  end

  assign rot_o   = stage;
  assign carry_o = lsl_i ? stage[0] : stage[DATA_W-1];

endmodule

// File: rtl/operand2_shifter.sv
// Operand-2 shifter with a one-entry registered output (valid/ready).
// Build option: define OP2_REG_SHIFT_EN to honour register-specified shift
// amounts (reg_shift / val_rs); otherwise those inputs are ignored and all
// shifts use the immediate amount from shift_operand.
module operand2_shifter
  import op2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [7:0]        val_rs,
  input  logic [11:0]       shift_operand,
  input  logic              los,
  input  logic              imm,
  input  logic              reg_shift,
  input  logic              carry_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

  localparam int          AW  = $clog2(DATA_W);
  localparam logic [31:0] W_U = DATA_W;

  shift_e            sh_type;
  logic [4:0]        sh_imm;
  logic [8:0]        sh_n;
  logic              sh_rrx;
  logic [AW-1:0]     sh_amt;

  logic [DATA_W-1:0] rot_in;
  logic [AW-1:0]     rot_amt;
  logic              rot_lsl;
  logic [DATA_W-1:0] rot_out;
  logic              rot_c;

  logic [DATA_W-1:0] lo_mask;
  logic [DATA_W-1:0] hi_mask;
  logic              n_zero;
  logic              n_eq;
  logic              n_big;
  logic              sign;
  logic [DATA_W-1:0] shifted;
  logic              shift_c;

  logic              accept;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic              carry_q, carry_d;

`ifndef OP2_REG_SHIFT_EN
  logic unused_reg_shift;
  assign unused_reg_shift = ^{reg_shift, val_rs};
`endif

  // Effective shift amount; immediate #0 encodes #32 for LSR/ASR and RRX for ROR.
  always_comb begin
    sh_type = shift_e'(shift_operand[SO_TYPE_MSB:SO_TYPE_LSB]);
    sh_imm  = shift_operand[SO_SHAMT_MSB:SO_SHAMT_LSB];
    sh_rrx  = 1'b0;
    sh_n    = {4'd0, sh_imm};
    if (sh_imm == 5'd0) begin
      if (sh_type == LSR || sh_type == ASR) begin
        sh_n = 9'd32;
      end else if (sh_type == ROR) begin
        sh_rrx = 1'b1;
        sh_n   = 9'd1;
      end
    end
`ifdef OP2_REG_SHIFT_EN
    if (reg_shift) begin
      sh_rrx = 1'b0;
      sh_n   = {1'b0, val_rs};
    end
`endif
  end

  // Rotator operands: the rotated immediate shares the one rotator with Rm shifts.
  always_comb begin
    sh_amt  = AW'(sh_n);
    rot_in  = val_rm;
    rot_amt = sh_amt;
    rot_lsl = 1'b0;
    if (imm) begin
      rot_in  = DATA_W'(shift_operand[SO_IMM8_MSB:0]);
      rot_amt = AW'({shift_operand[SO_ROT_MSB:SO_ROT_LSB], 1'b0});
    end else if (sh_type == LSL) begin
      rot_amt = AW'(0) - sh_amt;
      rot_lsl = 1'b1;
    end
  end

  op2_rotator #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_rotator (
    .data_i  (rot_in),
    .amt_i   (rot_amt),
    .lsl_i   (rot_lsl),
    .rot_o   (rot_out),
    .carry_o (rot_c)
  );

  // Mode select and masking of the rotated value into LSL/LSR/ASR/ROR results.
  always_comb begin
    lo_mask = {DATA_W{1'b1}} >> sh_amt;
    hi_mask = {DATA_W{1'b1}} << sh_amt;
    n_zero  = (sh_n == 9'd0);
    n_eq    = ({23'd0, sh_n} == W_U);
    n_big   = ({23'd0, sh_n} >= W_U);
    sign    = val_rm[DATA_W-1];
    shifted = val_rm;
    shift_c = carry_in;
    if (los) begin
      shifted = DATA_W'(shift_operand);
    end else if (imm) begin
      shifted = rot_out;
      shift_c = (shift_operand[SO_ROT_MSB:SO_ROT_LSB] == 4'd0) ? carry_in : rot_c;
    end else if (!n_zero) begin
      unique case (sh_type)
        LSL: begin
          if (n_big) begin
            shifted = '0;
            shift_c = n_eq & val_rm[0];
          end else begin
            shifted = rot_out & hi_mask;
            shift_c = rot_c;
          end
        end
        LSR: begin
          if (n_big) begin
            shifted = '0;
            shift_c = n_eq & sign;
          end else begin
            shifted = rot_out & lo_mask;
            shift_c = rot_c;
          end
        end
        ASR: begin
          if (n_big) begin
            shifted = {DATA_W{sign}};
            shift_c = sign;
          end else begin
            shifted = (rot_out & lo_mask) | ({DATA_W{sign}} & ~lo_mask);
            shift_c = rot_c;
          end
        end
        ROR: begin
          shifted = rot_out;
          shift_c = rot_c;
          if (sh_rrx) begin
            shifted[DATA_W-1] = carry_in;
          end
        end
      endcase
    end
  end

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Output slot: load on accept, drain on out_ready, drop on flush; hold otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    val2_d      = val2_q;
    carry_d     = carry_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      val2_d      = shifted;
      carry_d     = shift_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset clears any held result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      val2_q      <= '0;
      carry_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      val2_q      <= val2_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign val2      = val2_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_operand2_shifter.sv
// Scoreboard bench for operand2_shifter (DATA_W = 32). Expected results are
// hand-computed; register-shift vectors carry both expectations, selected by
// OP2_REG_SHIFT_EN.
module tb_operand2_shifter;

  typedef struct {
    string       name;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic [11:0] so;
    logic        los;
    logic        imm;
    logic        rsh;
    logic        cin;
    logic [31:0] ev;
    logic        ec;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] val_rm;
  logic [7:0]  val_rs;
  logic [11:0] shift_operand;
  logic        los;
  logic        imm;
  logic        reg_shift;
  logic        carry_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val2;
  logic        carry_out;

  vec_t exp_q[$];
  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  operand2_shifter #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .val_rm        (val_rm),
    .val_rs        (val_rs),
    .shift_operand (shift_operand),
    .los           (los),
    .imm           (imm),
    .reg_shift     (reg_shift),
    .carry_in      (carry_in),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .val2          (val2),
    .carry_out     (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [31:0] rm, input logic [7:0] rs,
                     input logic [11:0] so, input logic l, input logic i, input logic r,
                     input logic cin, input logic [31:0] ev, input logic ec);
    vec_t v;
    v.name = name; v.rm = rm; v.rs = rs; v.so = so; v.los = l; v.imm = i;
    v.rsh = r; v.cin = cin; v.ev = ev; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    val_rm        = v.rm;
    val_rs        = v.rs;
    shift_operand = v.so;
    los           = v.los;
    imm           = v.imm;
    reg_shift     = v.rsh;
    carry_in      = v.cin;
  endtask

  // Present v from posedge+1 until accepted; returns the number of stalled cycles.
  task automatic drive(input vec_t v, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    apply(v);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(v);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 20) begin
          n_vec++;
          n_fail++;
          $display("FAIL accept_timeout %s: in_ready stuck at 0", v.name);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every transfer pops the oldest expectation; a stalled result must match it too.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got %h/%0b, expected nothing", val2, carry_out);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check(e.name, {carry_out, val2}, {e.ec, e.ev});
        end else begin
          e = exp_q[0];
          check({"hold_", e.name}, {carry_out, val2}, {e.ec, e.ev});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    vec_t a;
    vec_t b;

    rst_n = 1'b0; in_valid = 1'b0; val_rm = '0; val_rs = '0; shift_operand = '0;
    los = 1'b0; imm = 1'b0; reg_shift = 1'b0; carry_in = 1'b0; flush = 1'b0;
    out_ready = 1'b1;

    add("los",         32'h0000_0000, 8'd0,  12'hABC, 1, 0, 0, 1, 32'h0000_0ABC, 1);
    add("imm_rot4",    32'h0000_0000, 8'd0,  12'h4FF, 0, 1, 0, 0, 32'hFF00_0000, 1);
    add("imm_rot0",    32'h0000_0000, 8'd0,  12'h0A5, 0, 1, 0, 1, 32'h0000_00A5, 1);
    add("imm_rot1",    32'h0000_0000, 8'd0,  12'h1FF, 0, 1, 0, 0, 32'hC000_003F, 1);
    add("los_over_imm",32'h0000_0000, 8'd0,  12'h4FF, 1, 1, 0, 0, 32'h0000_04FF, 0);
    add("lsl0",        32'h1234_5678, 8'd0,  12'h000, 0, 0, 0, 1, 32'h1234_5678, 1);
    add("lsl4",        32'h9234_5678, 8'd0,  12'h200, 0, 0, 0, 0, 32'h2345_6780, 1);
    add("lsl31",       32'h0000_0003, 8'd0,  12'hF80, 0, 0, 0, 0, 32'h8000_0000, 1);
    add("lsr1",        32'h0000_0003, 8'd0,  12'h0A0, 0, 0, 0, 0, 32'h0000_0001, 1);
    add("lsr32",       32'h8000_0000, 8'd0,  12'h020, 0, 0, 0, 0, 32'h0000_0000, 1);
    add("asr4",        32'h8000_000F, 8'd0,  12'h240, 0, 0, 0, 0, 32'hF800_0000, 1);
    add("asr32_pos",   32'h7FFF_FFFF, 8'd0,  12'h040, 0, 0, 0, 1, 32'h0000_0000, 0);
    add("ror8",        32'h1234_5678, 8'd0,  12'h460, 0, 0, 0, 1, 32'h7812_3456, 0);
    add("ror4",        32'h0000_000F, 8'd0,  12'h260, 0, 0, 0, 0, 32'hF000_0000, 1);
    add("rrx_c1",      32'h0000_0003, 8'd0,  12'h060, 0, 0, 0, 1, 32'h8000_0001, 1);
    add("rrx_c0",      32'h0000_0002, 8'd0,  12'h060, 0, 0, 0, 0, 32'h0000_0001, 0);
    add("reg_asr40",   32'h8000_0000, 8'd40, 12'h040, 0, 0, 1, 0, 32'hFFFF_FFFF, 1);
`ifdef OP2_REG_SHIFT_EN
    add("reg_ror32",   32'h8000_0001, 8'd32, 12'h060, 0, 0, 1, 0, 32'h8000_0001, 1);
    add("reg_lsl32",   32'h0000_0001, 8'd32, 12'h000, 0, 0, 1, 0, 32'h0000_0000, 1);
    add("reg_lsl33",   32'hFFFF_FFFF, 8'd33, 12'h000, 0, 0, 1, 1, 32'h0000_0000, 0);
    add("reg_lsr32",   32'h8000_0000, 8'd32, 12'h020, 0, 0, 1, 0, 32'h0000_0000, 1);
    add("reg_lsr4",    32'h0000_00F8, 8'd4,  12'h420, 0, 0, 1, 0, 32'h0000_000F, 1);
    add("reg_n0",      32'h0000_0003, 8'd0,  12'h0A0, 0, 0, 1, 0, 32'h0000_0003, 0);
    add("reg_ror36",   32'h0000_000F, 8'd36, 12'h060, 0, 0, 1, 0, 32'hF000_0000, 1);
`else
    add("reg_ror32",   32'h8000_0001, 8'd32, 12'h060, 0, 0, 1, 0, 32'h4000_0000, 1);
    add("reg_lsl32",   32'h0000_0001, 8'd32, 12'h000, 0, 0, 1, 0, 32'h0000_0001, 0);
    add("reg_lsl33",   32'hFFFF_FFFF, 8'd33, 12'h000, 0, 0, 1, 1, 32'hFFFF_FFFF, 1);
    add("reg_lsr32",   32'h8000_0000, 8'd32, 12'h020, 0, 0, 1, 0, 32'h0000_0000, 1);
    add("reg_lsr4",    32'h0000_00F8, 8'd4,  12'h420, 0, 0, 1, 0, 32'h0000_0000, 1);
    add("reg_n0",      32'h0000_0003, 8'd0,  12'h0A0, 0, 0, 1, 0, 32'h0000_0001, 1);
    add("reg_ror36",   32'h0000_000F, 8'd36, 12'h060, 0, 0, 1, 0, 32'h0000_0007, 1);
`endif

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {32'd0, out_valid}, 33'd0);
    check("rst_val2_carry", {carry_out, val2}, 33'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", {32'd0, in_ready}, 33'd1);

    // Back-to-back directed vectors: each must be taken with no stall.
    foreach (vecs[i]) begin
      drive(vecs[i], w);
      check({"no_stall_", vecs[i].name}, 33'(w), 33'd0);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: result held, in_ready low for 3 cycles, then drains.
    a = vecs[1];
    b = vecs[6];
    out_ready = 1'b0;
    apply(a);
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_accept_first", {32'd0, in_ready}, 33'd1);
    exp_q.push_back(a);
    @(posedge clk);
    #1;
    apply(b);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", {32'd0, in_ready}, 33'd0);
      check("bp_out_valid", {32'd0, out_valid}, 33'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {32'd0, in_ready}, 33'd1);
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    for (int i = 2; i < 6; i++) begin
      drive(vecs[i], w);
      check({"bp_throughput_", vecs[i].name}, 33'(w), 33'd0);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Flush: held result dropped, request offered alongside flush is refused.
    out_ready = 1'b0;
    apply(vecs[8]);
    in_valid = 1'b1;
    @(negedge clk);
    check("fl_accept", {32'd0, in_ready}, 33'd1);
    exp_q.push_back(vecs[8]);
    @(posedge clk);
    #1;
    apply(vecs[9]);
    flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready_low", {32'd0, in_ready}, 33'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    check("fl_out_valid_cleared", {32'd0, out_valid}, 33'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fl_no_late_output", {32'd0, out_valid}, 33'd0);
    @(posedge clk);
    #1;

    // Reset mid-transfer: outputs clear immediately and nothing appears afterwards.
    out_ready = 1'b0;
    apply(vecs[10]);
    in_valid = 1'b1;
    @(negedge clk);
    exp_q.push_back(vecs[10]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    check("rs_held_valid", {32'd0, out_valid}, 33'd1);
    rst_n = 1'b0;
    #1;
    check("rs_out_valid_async", {32'd0, out_valid}, 33'd0);
    check("rs_val2_carry_async", {carry_out, val2}, 33'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rs_no_output_after", {32'd0, out_valid}, 33'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 33'(exp_q.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
